// File: rtl/reset_seq.sv
// reset_seq: staged reset sequencer releasing per-domain resets once PLL lock is stable
module reset_seq #(
    parameter int N_STAGES    = 3,
    parameter int HOLD_CYC    = 32,
    parameter int LOCK_CYC    = 16,
    parameter int STAGE_CYC   = 8,
    parameter int TIMEOUT_CYC = 65535,
    parameter int CW          = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pll_locked_i,
    input  logic                sw_rst_i,
    output logic [N_STAGES-1:0] rst_o,
    output logic                ready_o,
    output logic                lock_err_o,
    output logic [2:0]          state_o
);
    typedef enum logic [2:0] {HOLD = 3'd0, WAIT_LOCK = 3'd1, RELEASE = 3'd2, RUN = 3'd3} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, stab, stab_nxt;
    logic [N_STAGES-1:0] rst_nxt;
    logic [1:0] sync;
    logic ready_nxt, err_nxt, lock_s, abort;
    assign lock_s = sync[1];
    assign state_o = state;
    assign abort = sw_rst_i || (!lock_s && (state == RELEASE || state == RUN));
    // two-flop synchronizer for the asynchronous lock flag
    always_ff @(posedge clk)
        if (!reset_n) sync <= '0;
        else sync <= {sync[0], pll_locked_i};
    // next state, shared hold/timeout/stage counter, stable counter and output values
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt + 1'b1;
        stab_nxt = '0;
        rst_nxt = rst_o;
        ready_nxt = 1'b0;
        err_nxt = 1'b0;
        case (state)
            HOLD: begin
                rst_nxt = '1;
                if (sw_rst_i) cnt_nxt = '0;
                else if (cnt == CW'(HOLD_CYC - 1)) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt = '0;
                end
            end
            WAIT_LOCK: begin
                rst_nxt = '1;
                stab_nxt = lock_s ? stab + 1'b1 : '0;
                if (abort) begin
                    state_nxt = HOLD;
                    cnt_nxt = '0;
                    stab_nxt = '0;
                end else if (lock_s && stab == CW'(LOCK_CYC - 1)) begin
                    state_nxt = RELEASE;
                    cnt_nxt = '0;
                    stab_nxt = '0;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_nxt = HOLD;
                    cnt_nxt = '0;
                    stab_nxt = '0;
                    err_nxt = 1'b1;
                end
            end
            RELEASE: begin
                if (abort) begin
                    state_nxt = HOLD;
                    cnt_nxt = '0;
                    rst_nxt = '1;
                end else if (cnt == CW'(STAGE_CYC - 1)) begin
                    cnt_nxt = '0;
                    rst_nxt = rst_o << 1;
                    if (rst_nxt == '0) begin
                        state_nxt = RUN;
                        ready_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_nxt = '0;
                rst_nxt = '0;
                ready_nxt = 1'b1;
                if (abort) begin
                    state_nxt = HOLD;
                    rst_nxt = '1;
                    ready_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = HOLD;
                cnt_nxt = '0;
                rst_nxt = '1;
            end
        endcase
    end
    // state and output registers
    always_ff @(posedge clk)
        if (!reset_n) begin
            state <= HOLD;
            cnt <= '0;
            stab <= '0;
            rst_o <= '1;
            ready_o <= 1'b0;
            lock_err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            stab <= stab_nxt;
            rst_o <= rst_nxt;
            ready_o <= ready_nxt;
            lock_err_o <= err_nxt;
        end
endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: timeline and scoreboard checks of the staged reset sequencer
module tb_reset_seq;
    localparam int H = 32, L = 16, S = 8, T = 100;
    typedef struct packed {
        logic [2:0] rst;
        logic       rdy;
        logic       err;
        logic [2:0] st;
    } exp_t;
    typedef struct {
        int         e;
        logic [2:0] rst;
        logic       rdy;
        logic [2:0] st;
    } cp_t;
    localparam exp_t RST = 8'b111_0_0_000;

    logic clk, reset_n, pll, sw;
    logic [2:0] rst_o, state_o;
    logic ready_o, lock_err_o;
    int n_chk = 0, n_fail = 0, ed = 0;
    string tname;
    exp_t sb[$];
    cp_t cps[12];

    reset_seq #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset_n(reset_n), .pll_locked_i(pll), .sw_rst_i(sw),
        .rst_o(rst_o), .ready_o(ready_o), .lock_err_o(lock_err_o), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected outputs at edge e of a clean sequence whose RELEASE starts at edge tr
    function automatic exp_t tl(input int e, input int tr);
        exp_t x;
        x.st = e < H ? 3'd0 : e < tr ? 3'd1 : e < tr + 3 * S ? 3'd2 : 3'd3;
        for (int k = 0; k < 3; k++) x.rst[k] = e < tr + S * (k + 1);
        x.rdy = e >= tr + 3 * S;
        x.err = 1'b0;
        return x;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s/%s edge %0d: got %b required %b", tname, nm, ed, act, req);
        end
    endtask

    task automatic tick(input logic p, input logic s, input logic rn, input exp_t ex, input bit full);
        exp_t want;
        pll = p;
        sw = s;
        reset_n = rn;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        ed++;
        want = sb.pop_front();
        if (full) check("rst_rdy_err_st", {rst_o, ready_o, lock_err_o, state_o}, want);
        else check("lock_err", {7'd0, lock_err_o}, {7'd0, want.err});
    endtask

    task automatic do_reset(input logic p);
        tick(p, 1'b0, 1'b0, RST, 1'b1);
        tick(p, 1'b0, 1'b0, RST, 1'b1);
        ed = 0;
    endtask

    initial begin
        exp_t x;
        int m;
        reset_n = 1'b0;
        pll = 1'b0;
        sw = 1'b0;
        cps[0]  = '{1,  3'b111, 1'b0, 3'd0};
        cps[1]  = '{31, 3'b111, 1'b0, 3'd0};
        cps[2]  = '{32, 3'b111, 1'b0, 3'd1};
        cps[3]  = '{47, 3'b111, 1'b0, 3'd1};
        cps[4]  = '{48, 3'b111, 1'b0, 3'd2};
        cps[5]  = '{55, 3'b111, 1'b0, 3'd2};
        cps[6]  = '{56, 3'b110, 1'b0, 3'd2};
        cps[7]  = '{63, 3'b110, 1'b0, 3'd2};
        cps[8]  = '{64, 3'b100, 1'b0, 3'd2};
        cps[9]  = '{71, 3'b100, 1'b0, 3'd2};
        cps[10] = '{72, 3'b000, 1'b1, 3'd3};
        cps[11] = '{80, 3'b000, 1'b1, 3'd3};

        tname = "powerup";
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) begin
            while (ed < cps[i].e - 1) tick(1'b1, 1'b0, 1'b1, tl(ed + 1, H + L), 1'b0);
            x = {cps[i].rst, cps[i].rdy, 1'b0, cps[i].st};
            tick(1'b1, 1'b0, 1'b1, x, 1'b1);
        end

        tname = "run_lock_drop_then_sw";
        for (int e = 81; e <= 216; e++) begin
            x = e < 83 ? tl(e, H + L) : e < 141 ? tl(e - 83, H + L) : tl(e - 141, H + L);
            tick(e != 81, e == 141, 1'b1, x, 1'b1);
        end
        tname = "reset_in_run";
        tick(1'b1, 1'b0, 1'b0, RST, 1'b1);
        check("lock_s", {7'd0, dut.lock_s}, 8'd0);
        for (int e = 218; e <= 300; e++) tick(1'b1, 1'b0, 1'b1, tl(e - 217, H + L), 1'b1);

        tname = "lock_glitch";
        do_reset(1'b0);
        for (int e = 1; e <= 90; e++)
            tick((e >= 33 && e <= 42) || e >= 44, 1'b0, 1'b1, tl(e, 61), 1'b1);

        tname = "lock_timeout";
        do_reset(1'b0);
        for (int e = 1; e <= 270; e++) begin
            m = (e - 1) % (H + T) + 1;
            x.rst = 3'b111;
            x.rdy = 1'b0;
            x.err = m == H + T;
            x.st = (m >= H && m < H + T) ? 3'd1 : 3'd0;
            tick(1'b0, 1'b0, 1'b1, x, 1'b1);
        end

        tname = "sw_in_hold_and_wait";
        do_reset(1'b1);
        for (int e = 1; e <= 130; e++) begin
            x = e < 20 ? tl(e, H + L) : e < 60 ? tl(e - 20, H + L) : tl(e - 60, H + L);
            tick(1'b1, e == 20 || e == 60, 1'b1, x, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
